// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider controller: FSM encoding, data width,
// default timeout and the quotient reported on division by zero.
package div_ctrl_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 32;

    localparam logic [DATA_W-1:0] QUO_DIV_ZERO = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/arbitro_rr_2.sv
// Two-way round-robin arbiter: on contention the requester that was not
// granted last wins; a sole requester always wins. Output grant is one-hot.
module arbitro_rr_2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/controlador_divisor.sv
// Shares one external divider between two requesters with round-robin access.
// Optional RUN-state abort after TIMEOUT_CYCLES is enabled by DIV_TIMEOUT_EN.
module controlador_divisor
    import div_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_dividendo,
    input  logic [DATA_W-1:0] req0_divisor,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_dividendo,
    input  logic [DATA_W-1:0] req1_divisor,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_quociente,
    output logic [DATA_W-1:0] resp0_resto,
    output logic              resp0_div_zero,
    output logic              resp0_err,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_quociente,
    output logic [DATA_W-1:0] resp1_resto,
    output logic              resp1_div_zero,
    output logic              resp1_err,
    output logic              div_start,
    output logic [DATA_W-1:0] div_dividendo,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quociente,
    input  logic [DATA_W-1:0] div_resto,
    output logic              busy,
    output logic              grant_id
);

    state_t            state_q, state_d;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;
    logic [DATA_W-1:0] sel_dvd, sel_dvs;
    logic              last_grant_q, grant_id_q;
    logic [DATA_W-1:0] op_dvd_q, op_dvs_q;
    logic [DATA_W-1:0] res_quo_q, res_rem_q;
    logic              res_zero_q, res_err_q;
    logic              timeout;

    arbitro_rr_2 u_arbitro (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept  = (state_q == IDLE) && (grant != '0);
    assign sel     = grant[1];
    assign sel_dvd = sel ? req1_dividendo : req0_dividendo;
    assign sel_dvs = sel ? req1_divisor   : req0_divisor;

`ifdef DIV_TIMEOUT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == LOAD) begin
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // cnt_q counts completed RUN cycles, so this fires in the last allowed one
    assign timeout = (state_q == RUN) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (sel_dvs == '0) ? RESP : LOAD;
            LOAD: state_d = RUN;
            RUN:  if (div_done || timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            op_dvd_q     <= '0;
            op_dvs_q     <= '0;
            res_quo_q    <= '0;
            res_rem_q    <= '0;
            res_zero_q   <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_id_q <= sel;
                        op_dvd_q   <= sel_dvd;
                        op_dvs_q   <= sel_dvs;
                        if (sel_dvs == '0) begin
                            res_quo_q  <= QUO_DIV_ZERO;
                            res_rem_q  <= sel_dvd;
                            res_zero_q <= 1'b1;
                            res_err_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (div_done) begin
                        res_quo_q  <= div_quociente;
                        res_rem_q  <= div_resto;
                        res_zero_q <= 1'b0;
                        res_err_q  <= 1'b0;
                    end else if (timeout) begin
                        res_quo_q  <= '0;
                        res_rem_q  <= '0;
                        res_zero_q <= 1'b0;
                        res_err_q  <= 1'b1;
                    end
                end
                RESP: last_grant_q <= grant_id_q;
                default: ;
            endcase
        end
    end

    // ready is combinational from the arbiter, so it is masked while rst is held
    always_comb begin
        req0_ready      = accept && !sel && !rst;
        req1_ready      = accept &&  sel && !rst;
        resp0_valid     = 1'b0;
        resp0_quociente = '0;
        resp0_resto     = '0;
        resp0_div_zero  = 1'b0;
        resp0_err       = 1'b0;
        resp1_valid     = 1'b0;
        resp1_quociente = '0;
        resp1_resto     = '0;
        resp1_div_zero  = 1'b0;
        resp1_err       = 1'b0;
        if (state_q == RESP) begin
            if (!grant_id_q) begin
                resp0_valid     = 1'b1;
                resp0_quociente = res_quo_q;
                resp0_resto     = res_rem_q;
                resp0_div_zero  = res_zero_q;
                resp0_err       = res_err_q;
            end else begin
                resp1_valid     = 1'b1;
                resp1_quociente = res_quo_q;
                resp1_resto     = res_rem_q;
                resp1_div_zero  = res_zero_q;
                resp1_err       = res_err_q;
            end
        end
    end

    assign div_start     = (state_q == LOAD) || (state_q == RUN);
    assign div_dividendo = op_dvd_q;
    assign div_divisor   = op_dvs_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_id_q;

endmodule
